// File: rtl/lsq_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lsq_mem_arbiter
//
// Sequences one memory operation at a time between the load queue head, the
// store queue head and the single data-cache port. The older of the two heads
// wins. Loads get their returned word lane-aligned and sign/zero-extended, then
// broadcast with the ROB tag. Stores get byte enables and lane-shifted data.
//
// Handshake (valid/ready): a queue head raises ld_req/st_req and holds its
// fields stable until the matching one-cycle ld_done/st_done pulse, which
// also means "dequeue your head". The cache sees a level request
// (mem_read/mem_write) held until a single-cycle mem_resp. A mem_resp that
// arrives while no request is outstanding is ignored.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   flush           kills an in-flight load result; never affects stores
//   ld_req/addr/funct3/tag         load queue head
//   st_req/addr/data/funct3        store queue head (committed)
//   ld_older        load head older than store head (when both valid)
//   ld_done, ld_rdy_tag, ld_data   load completion broadcast
//   st_done         store completion
//   mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
//   mem_resp, mem_rdata            cache port
//   dbg_state       FSM state: 0 IDLE, 1 READ, 2 WRITE, 3 DRAIN
// -----------------------------------------------------------------------------
module lsq_mem_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_funct3,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_req,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_funct3,
    input  logic             ld_older,
    output logic             ld_done,
    output logic [TAG_W-1:0] ld_rdy_tag,
    output logic [31:0]      ld_data,
    output logic             st_done,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byte_enable,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    input  logic             mem_resp,
    input  logic [31:0]      mem_rdata,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Latched request fields. The store data is kept already lane-aligned.
    logic [31:0]      r_addr,   w_addr_nxt;
    logic [2:0]       r_funct3, w_funct3_nxt;
    logic [TAG_W-1:0] r_tag,    w_tag_nxt;
    logic [31:0]      r_wdata,  w_wdata_nxt;
    logic [3:0]       r_be,     w_be_nxt;

    // Registered outputs
    logic             r_mem_read,  w_mem_read_nxt;
    logic             r_mem_write, w_mem_write_nxt;
    logic             r_ld_done,   w_ld_done_nxt;
    logic             r_st_done,   w_st_done_nxt;
    logic [TAG_W-1:0] r_ld_tag,    w_ld_tag_nxt;
    logic [31:0]      r_ld_data,   w_ld_data_nxt;

    logic             w_pick_ld;
    logic [31:0]      w_rd_shift;
    logic [31:0]      w_ld_ext;
    logic [3:0]       w_be_base;
    logic [3:0]       w_st_be;
    logic [31:0]      w_st_wdata;

    // Load wins when it is the only candidate or the older one; flush masks it.
    assign w_pick_ld = ld_req && !flush && (!st_req || ld_older);

    // Load alignment and extension, from the latched offset and funct3.
    assign w_rd_shift = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld_ext = w_rd_shift;
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_rd_shift[7]}},  w_rd_shift[7:0]};
            3'b001:  w_ld_ext = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b100:  w_ld_ext = {24'd0, w_rd_shift[7:0]};
            3'b101:  w_ld_ext = {16'd0, w_rd_shift[15:0]};
            default: w_ld_ext = w_rd_shift;
        endcase
    end

    // Store lanes. Upper enables that shift past lane 3 are simply dropped,
    // so a misaligned store writes a truncated set of lanes without trapping.
    always_comb begin
        w_be_base = 4'b0000;
        case (st_funct3)
            3'b000:  w_be_base = 4'b0001;
            3'b001:  w_be_base = 4'b0011;
            3'b010:  w_be_base = 4'b1111;
            default: w_be_base = 4'b0000;
        endcase
    end

    assign w_st_be    = w_be_base << st_addr[1:0];
    assign w_st_wdata = st_data << {st_addr[1:0], 3'b000};

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_funct3_nxt    = r_funct3;
        w_tag_nxt       = r_tag;
        w_wdata_nxt     = r_wdata;
        w_be_nxt        = r_be;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_ld_done_nxt   = 1'b0;
        w_st_done_nxt   = 1'b0;
        w_ld_tag_nxt    = r_ld_tag;
        w_ld_data_nxt   = r_ld_data;

        case (r_state)
            S_IDLE: begin
                if (w_pick_ld) begin
                    w_state_nxt    = S_READ;
                    w_addr_nxt     = ld_addr;
                    w_funct3_nxt   = ld_funct3;
                    w_tag_nxt      = ld_tag;
                    w_mem_read_nxt = 1'b1;
                end else if (st_req) begin
                    w_state_nxt     = S_WRITE;
                    w_addr_nxt      = st_addr;
                    w_funct3_nxt    = st_funct3;
                    w_wdata_nxt     = w_st_wdata;
                    w_be_nxt        = w_st_be;
                    w_mem_write_nxt = 1'b1;
                end
            end

            S_READ: begin
                if (mem_resp) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_read_nxt = 1'b0;
                    if (!flush) begin
                        w_ld_done_nxt = 1'b1;
                        w_ld_tag_nxt  = r_tag;
                        w_ld_data_nxt = w_ld_ext;
                    end
                end else if (flush) begin
                    // The cache still owes a response; wait it out silently.
                    w_state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (mem_resp) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_read_nxt = 1'b0;
                end
            end

            S_WRITE: begin
                if (mem_resp) begin
                    w_state_nxt     = S_IDLE;
                    w_mem_write_nxt = 1'b0;
                    w_be_nxt        = 4'b0000;
                    w_wdata_nxt     = 32'd0;
                    w_st_done_nxt   = 1'b1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_funct3    <= 3'd0;
            r_tag       <= '0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ld_done   <= 1'b0;
            r_st_done   <= 1'b0;
            r_ld_tag    <= '0;
            r_ld_data   <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_funct3    <= w_funct3_nxt;
            r_tag       <= w_tag_nxt;
            r_wdata     <= w_wdata_nxt;
            r_be        <= w_be_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_ld_done   <= w_ld_done_nxt;
            r_st_done   <= w_st_done_nxt;
            r_ld_tag    <= w_ld_tag_nxt;
            r_ld_data   <= w_ld_data_nxt;
        end
    end

    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_be;
    assign mem_address     = {r_addr[31:2], 2'b00};
    assign mem_wdata       = r_wdata;
    assign ld_done         = r_ld_done;
    assign ld_rdy_tag      = r_ld_tag;
    assign ld_data         = r_ld_data;
    assign st_done         = r_st_done;
    assign dbg_state       = r_state;

endmodule
